inst_encoder: RTL and testbench

//  Inverse of the instruction decoder: packs field-level requests (kind, alu_op, rd, rs1, rs2, imm)

---
 rtl/inst_encoder_pkg.sv | 97 +++++++++
 rtl/inst_field_pack.sv | 70 +++++++
 rtl/inst_encoder.sv | 100 ++++++++++
 tb/tb_inst_encoder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared encoding tables for the RV32I instruction encoder: request kinds, ALU op codes,
// opcodes, funct3 values and immediate range limits (the limits are used only with ENC_RANGE_CHECK_EN).
package inst_encoder_pkg;

   localparam int XLEN     = 32;
   localparam int REG_W    = 5;
   localparam int ALU_OP_W = 4;

   typedef enum logic [1:0] {
      ENC_KIND_BRANCH  = 2'd0,
      ENC_KIND_ALU_IMM = 2'd1,
      ENC_KIND_ALU_REG = 2'd2,
      ENC_KIND_ECALL   = 2'd3
   } enc_kind_e;

   // Arithmetic/logic ops first; the six branch compares share the same code space.
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_OP_ADD  = 4'd0,
      ALU_OP_SUB  = 4'd1,
      ALU_OP_SLL  = 4'd2,
      ALU_OP_SLT  = 4'd3,
      ALU_OP_SLTU = 4'd4,
      ALU_OP_XOR  = 4'd5,
      ALU_OP_SRL  = 4'd6,
      ALU_OP_SRA  = 4'd7,
      ALU_OP_OR   = 4'd8,
      ALU_OP_AND  = 4'd9,
      ALU_OP_EQ   = 4'd10,
      ALU_OP_NE   = 4'd11,
      ALU_OP_LT   = 4'd12,
      ALU_OP_GE   = 4'd13,
      ALU_OP_LTU  = 4'd14,
      ALU_OP_GEU  = 4'd15
   } alu_op_e;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [XLEN-1:0] ECALL_WORD = {25'd0, OPC_SYSTEM};

   localparam int IMM_I_MIN  = -2048;
   localparam int IMM_I_MAX  = 2047;
   localparam int SHAMT_MAX  = 31;
   localparam int BR_OFF_MIN = -4096;
   localparam int BR_OFF_MAX = 4094;

   function automatic logic is_cmp_op(input alu_op_e op);
      return op inside {ALU_OP_EQ, ALU_OP_NE, ALU_OP_LT, ALU_OP_GE, ALU_OP_LTU, ALU_OP_GEU};
   endfunction

   function automatic logic is_shift_op(input alu_op_e op);
      return op inside {ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA};
   endfunction

   function automatic logic [2:0] branch_f3(input alu_op_e op);
      case (op)
         ALU_OP_NE:  return F3_BNE;
         ALU_OP_LT:  return F3_BLT;
         ALU_OP_GE:  return F3_BGE;
         ALU_OP_LTU: return F3_BLTU;
         ALU_OP_GEU: return F3_BGEU;
         default:    return F3_BEQ;
      endcase
   endfunction

   function automatic logic [2:0] alu_f3(input alu_op_e op);
      case (op)
         ALU_OP_SLL:             return F3_SLL;
         ALU_OP_SLT:             return F3_SLT;
         ALU_OP_SLTU:            return F3_SLTU;
         ALU_OP_XOR:             return F3_XOR;
         ALU_OP_SRL, ALU_OP_SRA: return F3_SRL_SRA;
         ALU_OP_OR:              return F3_OR;
         ALU_OP_AND:             return F3_AND;
         default:                return F3_ADD_SUB;
      endcase
   endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: kind/alu_op/registers/immediate -> 32-bit RV32I word plus an unencodable flag.
// With ENC_RANGE_CHECK_EN defined, out-of-range immediates are flagged instead of truncated.
module inst_field_pack
   import inst_encoder_pkg::*;
(
   input  logic [1:0]          kind,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [REG_W-1:0]    rd,
   input  logic [REG_W-1:0]    rs1,
   input  logic [REG_W-1:0]    rs2,
   input  logic [XLEN-1:0]     imm,
   output logic [XLEN-1:0]     word,
   output logic                bad
);

   alu_op_e op;
   logic    sra_bit;
   logic    funct7_bit30;
   logic    br_range_bad;
   logic    i_range_bad;
   logic    sh_range_bad;

   assign op           = alu_op_e'(alu_op);
   assign sra_bit      = (op == ALU_OP_SRA);
   assign funct7_bit30 = (op == ALU_OP_SUB) || (op == ALU_OP_SRA);

`ifdef ENC_RANGE_CHECK_EN
   logic signed [XLEN-1:0] imm_s;
   assign imm_s        = imm;
   assign br_range_bad = (imm_s < BR_OFF_MIN) || (imm_s > BR_OFF_MAX);
   assign i_range_bad  = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
   assign sh_range_bad = (imm_s < 0) || (imm_s > SHAMT_MAX);
`else
   // Without range checking the upper immediate bits are simply dropped.
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm[XLEN-1:13];
   assign br_range_bad  = 1'b0;
   assign i_range_bad   = 1'b0;
   assign sh_range_bad  = 1'b0;
`endif

   always_comb begin
      // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
      word = '0;
      bad  = 1'b0;
      case (enc_kind_e'(kind))
         ENC_KIND_BRANCH: begin
            bad  = !is_cmp_op(op) || imm[0] || br_range_bad;
            word = {imm[12], imm[10:5], rs2, rs1, branch_f3(op), imm[4:1], imm[11], OPC_BRANCH};
         end
         ENC_KIND_ALU_IMM: begin
            if (is_shift_op(op)) begin
               bad  = sh_range_bad;
               word = {1'b0, sra_bit, 5'd0, imm[4:0], rs1, alu_f3(op), rd, OPC_OP_IMM};
            end else begin
               bad  = is_cmp_op(op) || (op == ALU_OP_SUB) || i_range_bad;
               word = {imm[11:0], rs1, alu_f3(op), rd, OPC_OP_IMM};
            end
         end
         ENC_KIND_ALU_REG: begin
            bad  = is_cmp_op(op);
            word = {1'b0, funct7_bit30, 5'd0, rs2, rs1, alu_f3(op), rd, OPC_OP};
         end
         ENC_KIND_ECALL: begin
            word = ECALL_WORD;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Streams packed RV32I words with byte addresses into instruction memory through one registered
// valid/ready stage. Optional macro ENC_RANGE_CHECK_EN enables immediate range errors in inst_field_pack.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_kind,
   input  logic [ALU_OP_W-1:0] in_alu_op,
   input  logic [REG_W-1:0]    in_rd,
   input  logic [REG_W-1:0]    in_rs1,
   input  logic [REG_W-1:0]    in_rs2,
   input  logic [XLEN-1:0]     in_imm,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_word,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                err,
   output logic [15:0]         word_cnt
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic [XLEN-1:0]   pack_word;
   logic              pack_bad;
   logic              accept;
   logic              push;
   logic              pop;

   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_word_q,  out_word_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic [15:0]       word_cnt_q,  word_cnt_d;
   logic              err_q,       err_d;

   inst_field_pack u_pack (
      .kind   (in_kind),
      .alu_op (in_alu_op),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .imm    (in_imm),
      .word   (pack_word),
      .bad    (pack_bad)
   );

   // A word leaving this cycle frees the register, so a new request can land without a bubble.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign push     = accept && !pack_bad;
   assign pop      = out_valid_q && out_ready;

   always_comb begin
      out_valid_d = out_valid_q && !out_ready;
      out_word_d  = out_word_q;
      out_addr_d  = out_addr_q;
      word_cnt_d  = word_cnt_q;
      err_d       = accept && pack_bad;
      if (pop) begin
         out_addr_d = out_addr_q + ADDR_STEP;
         if (word_cnt_q != 16'hFFFF) begin
            word_cnt_d = word_cnt_q + 16'd1;
         end
      end
      if (push) begin
         out_valid_d = 1'b1;
         out_word_d  = pack_word;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      if (rst) begin
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_addr_q  <= BASE;
         word_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         out_addr_q  <= out_addr_d;
         word_cnt_q  <= word_cnt_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign out_addr  = out_addr_q;
   assign word_cnt  = word_cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder (ADDR_W=4, BASE_ADDR=8): directed encodings, stall,
// error pulses, reset mid-stream and a randomized run against a spec-level scoreboard.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   localparam int ADDR_W = 4;
   localparam int BASE   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        in_kind = 2'd0;
   logic [3:0]        in_alu_op = 4'd0;
   logic [4:0]        in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
   logic [31:0]       in_imm = 32'd0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [31:0]       out_word;
   logic [ADDR_W-1:0] out_addr;
   logic              err;
   logic [15:0]       word_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_alu_op (in_alu_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_addr  (out_addr),
      .err       (err),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference encoder built from the RV32I field tables with plain shifts and masks.
   function automatic void ref_encode(input logic [1:0] k, input logic [3:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm,
                                      output logic [31:0] w, output bit bad);
      int f3;
      bit cmp;
      bit shift;
      int simm;
      simm  = int'(imm);
      cmp   = 1'b0;
      shift = (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
      case (op)
         ALU_OP_EQ:   begin cmp = 1'b1; f3 = 0; end
         ALU_OP_NE:   begin cmp = 1'b1; f3 = 1; end
         ALU_OP_LT:   begin cmp = 1'b1; f3 = 4; end
         ALU_OP_GE:   begin cmp = 1'b1; f3 = 5; end
         ALU_OP_LTU:  begin cmp = 1'b1; f3 = 6; end
         ALU_OP_GEU:  begin cmp = 1'b1; f3 = 7; end
         ALU_OP_SLL:  f3 = 1;
         ALU_OP_SLT:  f3 = 2;
         ALU_OP_SLTU: f3 = 3;
         ALU_OP_XOR:  f3 = 4;
         ALU_OP_SRL, ALU_OP_SRA: f3 = 5;
         ALU_OP_OR:   f3 = 6;
         ALU_OP_AND:  f3 = 7;
         default:     f3 = 0;
      endcase
      bad = 1'b0;
      w   = 32'd0;
      case (k)
         ENC_KIND_BRANCH: begin
            bad = !cmp || imm[0];
`ifdef ENC_RANGE_CHECK_EN
            if (simm < -4096 || simm > 4094) bad = 1'b1;
`endif
            w = 32'h63 | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(f3) << 12)
              | (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7);
         end
         ENC_KIND_ALU_IMM: begin
            bad = cmp || (op == ALU_OP_SUB);
`ifdef ENC_RANGE_CHECK_EN
            if (shift && (simm < 0 || simm > 31)) bad = 1'b1;
            if (!shift && (simm < -2048 || simm > 2047)) bad = 1'b1;
`endif
            w = 32'h13 | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
            if (shift) w = w | ((imm & 32'h1F) << 20) | ((op == ALU_OP_SRA) ? 32'h4000_0000 : 32'd0);
            else       w = w | ((imm & 32'hFFF) << 20);
         end
         ENC_KIND_ALU_REG: begin
            bad = cmp;
            w = 32'h33 | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
              | ((op == ALU_OP_SUB || op == ALU_OP_SRA) ? 32'h4000_0000 : 32'd0);
         end
         default: w = 32'h73;
      endcase
      if (simm == 0) w = w | 32'd0;
   endfunction

   // Scoreboard: queue of words the memory should receive, address and count models.
   logic [31:0] sb_q[$];
   int          addr_exp  = BASE;
   int          cnt_exp   = 0;
   bit          err_exp   = 1'b0;
   bit          mon_armed = 1'b0;

   always @(negedge clk) begin : scoreboard
      logic [31:0] w;
      bit          bad;
      bit          m_valid;
      bit          acc;
      #4;
      m_valid = (sb_q.size() != 0);
      if (mon_armed) begin
         n_checks++;
         if (out_valid !== m_valid) begin
            n_fail++; $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
         end
         n_checks++;
         if (in_ready !== (!m_valid || out_ready)) begin
            n_fail++; $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, !m_valid || out_ready, $time);
         end
         n_checks++;
         if (err !== err_exp) begin
            n_fail++; $display("FAIL sb_err: got %b expected %b at %0t", err, err_exp, $time);
         end
         n_checks++;
         if (word_cnt !== cnt_exp[15:0]) begin
            n_fail++; $display("FAIL sb_word_cnt: got %0d expected %0d at %0t", word_cnt, cnt_exp, $time);
         end
         if (m_valid) begin
            n_checks++;
            if (out_word !== sb_q[0] || out_addr !== addr_exp[ADDR_W-1:0]) begin
               n_fail++;
               $display("FAIL sb_word: got %h@%0d expected %h@%0d at %0t", out_word, out_addr, sb_q[0], addr_exp, $time);
            end
         end
      end
      if (rst) begin
         sb_q.delete();
         addr_exp  = BASE;
         cnt_exp   = 0;
         err_exp   = 1'b0;
         mon_armed = 1'b1;
      end else begin
         acc = in_valid && (!m_valid || out_ready);
         if (m_valid && out_ready) begin
            void'(sb_q.pop_front());
            addr_exp = (addr_exp + 4) % (1 << ADDR_W);
            if (cnt_exp < 65535) cnt_exp++;
         end
         err_exp = 1'b0;
         if (acc) begin
            ref_encode(in_kind, in_alu_op, in_rd, in_rs1, in_rs2, in_imm, w, bad);
            if (bad) err_exp = 1'b1;
            else sb_q.push_back(w);
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic send(input logic [1:0] k, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      in_valid = 1'b1; in_kind = k; in_alu_op = op;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      for (int i = 0; i < 50; i++) begin
         #4;
         if (in_ready === 1'b1) begin
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1 within 50 cycles", in_ready);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (out_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: valid=%b err=%b expected 0 0", out_valid, err);
         end
         n_checks++;
         if (word_cnt !== 16'd0 || out_word !== 32'd0) begin
            n_fail++; $display("FAIL reset_regs: cnt=%0d word=%h expected 0 0", word_cnt, out_word);
         end
         n_checks++;
         if (out_addr !== 4'd8) begin
            n_fail++; $display("FAIL reset_addr: got %0d expected 8", out_addr);
         end
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_encodings();
      logic [31:0] exp_w[5];
      logic [3:0]  exp_a[5];
      exp_w = '{32'h00110093, 32'hfe419ee3, 32'h41f5d513, 32'h404000b3, 32'h00000073};
      exp_a = '{4'd8, 4'd12, 4'd0, 4'd4, 4'd8};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: send(ENC_KIND_ALU_IMM, ALU_OP_ADD, 5'd1, 5'd2, 5'd0, 32'd1);
            1: send(ENC_KIND_BRANCH, ALU_OP_NE, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFFC);
            2: send(ENC_KIND_ALU_IMM, ALU_OP_SRA, 5'd10, 5'd11, 5'd0, 32'd31);
            3: send(ENC_KIND_ALU_REG, ALU_OP_SUB, 5'd1, 5'd0, 5'd4, 32'd0);
            default: send(ENC_KIND_ECALL, ALU_OP_AND, 5'd7, 5'd7, 5'd7, 32'd123);
         endcase
         n_checks++;
         if (out_valid !== 1'b1 || out_word !== exp_w[i] || out_addr !== exp_a[i]) begin
            n_fail++;
            $display("FAIL encode_%0d: got v=%b %h@%0d expected v=1 %h@%0d", i, out_valid, out_word, out_addr, exp_w[i], exp_a[i]);
         end
      end
      idle();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || word_cnt !== 16'd5 || out_addr !== 4'd12) begin
         n_fail++; $display("FAIL encode_drain: v=%b cnt=%0d addr=%0d expected 0 5 12", out_valid, word_cnt, out_addr);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wa, wb;
      bit          ba, bb;
      ref_encode(ENC_KIND_ALU_REG, ALU_OP_XOR, 5'd5, 5'd6, 5'd7, 32'd0, wa, ba);
      ref_encode(ENC_KIND_ALU_IMM, ALU_OP_SLTU, 5'd8, 5'd9, 5'd0, 32'hFFFF_F800, wb, bb);
      out_ready = 1'b0;
      send(ENC_KIND_ALU_REG, ALU_OP_XOR, 5'd5, 5'd6, 5'd7, 32'd0);
      in_kind = ENC_KIND_ALU_IMM; in_alu_op = ALU_OP_SLTU;
      in_rd = 5'd8; in_rs1 = 5'd9; in_rs2 = 5'd0; in_imm = 32'hFFFF_F800;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_in_ready_%0d: got %b expected 0", i, in_ready);
         end
         n_checks++;
         if (out_valid !== 1'b1 || out_word !== wa || out_addr !== 4'd12) begin
            n_fail++; $display("FAIL stall_hold_%0d: got v=%b %h@%0d expected v=1 %h@12", i, out_valid, out_word, out_addr, wa);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(ENC_KIND_ALU_IMM, ALU_OP_SLTU, 5'd8, 5'd9, 5'd0, 32'hFFFF_F800);
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== wb || out_addr !== 4'd0 || word_cnt !== 16'd6) begin
         n_fail++; $display("FAIL stall_second: got v=%b %h@%0d cnt=%0d expected v=1 %h@0 cnt=6", out_valid, out_word, out_addr, word_cnt, wb);
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_errors();
      out_ready = 1'b1;
      send(ENC_KIND_BRANCH, ALU_OP_ADD, 5'd0, 5'd1, 5'd2, 32'd8);
      idle();
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || out_addr !== 4'd4 || word_cnt !== 16'd7) begin
         n_fail++; $display("FAIL err_branch_add: err=%b v=%b addr=%0d cnt=%0d expected 1 0 4 7", err, out_valid, out_addr, word_cnt);
      end
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL err_pulse_width: got %b expected 0", err);
      end
      send(ENC_KIND_ALU_IMM, ALU_OP_SUB, 5'd1, 5'd1, 5'd0, 32'd3);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL err_b2b_first: got %b expected 1", err);
      end
      send(ENC_KIND_ALU_REG, ALU_OP_EQ, 5'd1, 5'd1, 5'd1, 32'd0);
      idle();
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_b2b_second: err=%b v=%b expected 1 0", err, out_valid);
      end
      send(ENC_KIND_BRANCH, ALU_OP_EQ, 5'd0, 5'd1, 5'd1, 32'd5);
      idle();
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_odd_branch: err=%b v=%b expected 1 0", err, out_valid);
      end
      @(negedge clk);
      send(ENC_KIND_ALU_IMM, ALU_OP_ADD, 5'd1, 5'd0, 5'd0, 32'd4096);
      idle();
`ifdef ENC_RANGE_CHECK_EN
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL imm_4096: err=%b v=%b expected 1 0", err, out_valid);
      end
`else
      n_checks++;
      if (err !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h00000093 || out_addr !== 4'd4) begin
         n_fail++; $display("FAIL imm_4096: err=%b v=%b %h@%0d expected 0 1 00000093@4", err, out_valid, out_word, out_addr);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stream();
      out_ready = 1'b0;
      send(ENC_KIND_ALU_IMM, ALU_OP_OR, 5'd3, 5'd4, 5'd0, 32'd2047);
      idle();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_pending: got %b expected 1", out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || out_addr !== 4'd8 || word_cnt !== 16'd0 || err !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid: v=%b addr=%0d cnt=%0d err=%b expected 0 8 0 0", out_valid, out_addr, word_cnt, err);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_discard: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_random();
      int          v;
      logic [3:0]  alu_ok[9];
      alu_ok = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR,
                 ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND};
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         in_kind   = 2'($urandom_range(0, 3));
         in_alu_op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) begin
            case (in_kind)
               ENC_KIND_BRANCH:  in_alu_op = 4'(10 + $urandom_range(0, 5));
               ENC_KIND_ALU_IMM: in_alu_op = alu_ok[$urandom_range(0, 8)];
               default:          in_alu_op = 4'($urandom_range(0, 9));
            endcase
         end
         in_rd  = 5'($urandom_range(0, 31));
         in_rs1 = 5'($urandom_range(0, 31));
         in_rs2 = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 31));
            1: v = int'($urandom_range(0, 127)) - 64;
            2: v = int'($urandom_range(0, 10000)) - 5000;
            default: v = int'($urandom);
         endcase
         in_imm = 32'(v);
         if (in_kind == ENC_KIND_BRANCH && $urandom_range(0, 4) != 0) in_imm[0] = 1'b0;
         @(negedge clk);
      end
      idle();
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_encodings();
      test_back_to_back();
      test_errors();
      test_reset_mid_stream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
